prbs31_checker: RTL and testbench

PRBS31_CHECKER -- requirements
Module: prbs31_checker

---
 rtl/prbs31_checker.sv | 126 ++++++++++++
 tb/tb_prbs31_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31+x^28+1) serial checker: locks by self-sync, then flywheels and counts bit errors.
// Latency: a valid bit sampled on edge N is reflected on all (registered) outputs in cycle N+1.
// No backpressure: bits are consumed whenever bit_valid=1. Optional bit counter: PRBS31_CHECKER_BITCNT_EN.
module prbs31_checker #(
  parameter int LOCK_THRESH = 64,
  parameter int UNLOCK_ERRS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state_q, state_nxt;
  logic [30:0] h_q, h_nxt;      // h_q[0] is the newest bit
  logic [7:0]  mcnt_q, mcnt_nxt; // consecutive matches while searching
  logic [5:0]  wcnt_q, wcnt_nxt; // position inside the 64-bit error window
  logic [6:0]  wmis_q, wmis_nxt; // mismatches seen in the current window
  logic        exp_bit;
  logic        mism;
  logic        err_hit;

  assign exp_bit = h_q[27] ^ h_q[30];
  assign mism    = bit_in ^ exp_bit;
  assign err_hit = bit_valid && (state_q == LOCKED) && mism;

  // Next-state logic: self-synchronising search, flywheel tracking once locked
  always_comb begin
    state_nxt = state_q;
    h_nxt     = h_q;
    mcnt_nxt  = mcnt_q;
    wcnt_nxt  = wcnt_q;
    wmis_nxt  = wmis_q;
    if (bit_valid) begin
      case (state_q)
        SEARCH: begin
          h_nxt = {h_q[29:0], bit_in};
          // An all-zero history trivially "matches"; it must not count toward lock
          if (!mism && (h_q != '0)) begin
            mcnt_nxt = mcnt_q + 8'd1;
            if ((32'(mcnt_q) + 32'd1) == 32'(LOCK_THRESH)) begin
              state_nxt = LOCKED;
              mcnt_nxt  = '0;
              wcnt_nxt  = '0;
              wmis_nxt  = '0;
            end
          end else begin
            mcnt_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel: feed back the predicted bit so a single line error is counted once
          h_nxt    = {h_q[29:0], exp_bit};
          wcnt_nxt = wcnt_q + 6'd1;
          wmis_nxt = wmis_q + {6'd0, mism};
          if (mism && ((32'(wmis_q) + 32'd1) == 32'(UNLOCK_ERRS))) begin
            state_nxt = SEARCH;
            mcnt_nxt  = '0;
          end
          if (wcnt_q == 6'd63) begin
            wmis_nxt = '0;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Core state registers; clr_err deliberately does not touch these
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      h_q     <= '0;
      mcnt_q  <= '0;
      wcnt_q  <= '0;
      wmis_q  <= '0;
    end else begin
      state_q <= state_nxt;
      h_q     <= h_nxt;
      mcnt_q  <= mcnt_nxt;
      wcnt_q  <= wcnt_nxt;
      wmis_q  <= wmis_nxt;
    end
  end

  // Registered status outputs and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_hit;
      if (clr_err) begin
        // An error landing with the clear is kept so none is lost
        err_cnt <= {15'd0, err_hit};
      end else if (err_hit && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

`ifdef PRBS31_CHECKER_BITCNT_EN
  // Saturating count of valid bits checked while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr_err) begin
      bit_cnt <= '0;
    end else if (bit_valid && (state_q == LOCKED) && (bit_cnt != 32'hFFFF_FFFF)) begin
      bit_cnt <= bit_cnt + 32'd1;
    end
  end
`else
  assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: directed lock/unlock/clear/reset sequences,
// a vector table for error counting and clear interaction, and a randomized run
// compared cycle by cycle against a stream-level reference model.
module tb_prbs31_checker;

  localparam int LOCK_THRESH = 64;
  localparam int UNLOCK_ERRS = 8;
`ifdef PRBS31_CHECKER_BITCNT_EN
  localparam bit BITCNT_EN = 1'b1;
`else
  localparam bit BITCNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prbs31_checker #(
    .LOCK_THRESH(LOCK_THRESH),
    .UNLOCK_ERRS(UNLOCK_ERRS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clr_err  (clr_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Stream generator: last 31 stream values r(n-31)..r(n-1); r(n) = r(n-28) ^ r(n-31)
  bit gq[$];

  task gen_bit(output bit b);
    b = gq[3] ^ gq[0];
    gq.push_back(b);
    void'(gq.pop_front());
  endtask

  // Reference model: history of what the checker believes the stream was
  bit              mh[$];
  bit              m_locked;
  bit              m_pulse;
  int              m_match;
  int              m_wcnt;
  int              m_wmis;
  int unsigned     m_err;
  longint unsigned m_bcnt;

  task model_reset();
    mh.delete();
    for (int i = 0; i < 31; i++) mh.push_back(1'b0);
    m_locked = 0; m_pulse = 0; m_match = 0; m_wcnt = 0; m_wmis = 0;
    m_err = 0; m_bcnt = 0;
  endtask

  task model_clock(input bit v, input bit b, input bit c);
    bit e;
    bit nz;
    bit hit;
    hit = 0;
    if (v) begin
      e  = mh[3] ^ mh[0];
      nz = 0;
      foreach (mh[i]) nz |= mh[i];
      if (!m_locked) begin
        mh.push_back(b);
        if (b == e && nz) m_match++;
        else m_match = 0;
        if (m_match == LOCK_THRESH) begin
          m_locked = 1; m_match = 0; m_wcnt = 0; m_wmis = 0;
        end
      end else begin
        mh.push_back(e);
        if (BITCNT_EN && m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
        m_wcnt++;
        if (b != e) begin
          hit = 1;
          if (m_err < 16'hFFFF) m_err++;
          m_wmis++;
        end
        if (hit && m_wmis == UNLOCK_ERRS) begin
          m_locked = 0; m_match = 0;
        end
        if (m_wcnt == 64) begin
          m_wcnt = 0; m_wmis = 0;
        end
      end
      void'(mh.pop_front());
    end
    if (c) begin
      m_err  = hit ? 1 : 0;
      m_bcnt = 0;
    end
    m_pulse = hit;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One input cycle: drive at negedge, model the edge, compare #1 after posedge
  task automatic step(input bit v, input bit inv, input bit c, input bit zero);
    bit b;
    @(negedge clk);
    if (v) begin
      if (zero) b = 1'b0;
      else begin
        gen_bit(b);
        b ^= inv;
      end
    end else begin
      b = 1'($urandom);
    end
    bit_valid = v;
    bit_in    = b;
    clr_err   = c;
    model_clock(v, b, c);
    @(posedge clk);
    #1;
    chk("model", 64'({locked, err_pulse, err_cnt, bit_cnt}),
        64'({m_locked, m_pulse, m_err[15:0], m_bcnt[31:0]}));
  endtask

  // Asynchronous reset between clock edges, outputs checked before any edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    clr_err   = 1'b0;
    model_reset();
    #1;
    chk("reset_outputs", 64'({locked, err_pulse, err_cnt, bit_cnt}), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          valid;
    bit          inv;
    bit          clr;
    bit          exp_locked;
    bit          exp_pulse;
    logic [15:0] exp_err;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[9];
    bit   found;
    bit   saw_lock;
    int   burst;
    bit   rv, ri, rc;

    // Entered right after a relock with err_cnt = 8
    tv[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};  // clear alone
    tv[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};  // single error
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};  // pulse lasts one cycle
    tv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};  // idle cycle holds
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};  // clear with error keeps it
    tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};  // clear with clean bit
    tv[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tv[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};  // invalid cycle ignores data

    for (int i = 0; i < 30; i++) gq.push_back(1'b0);
    gq.push_back(1'b1);  // seed 31'd1
    model_reset();

    do_reset();

    // Clean stream from seed: lock appears right after bit index 94
    for (int i = 0; i <= 94; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 93) chk("no_lock_before_94", 64'(locked), 64'd0);
      if (i == 94) chk("lock_at_94", 64'(locked), 64'd1);
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clean_err_cnt", 64'(err_cnt), 64'd0);
    chk("clean_still_locked", 64'(locked), 64'd1);

    // Eight errors inside one window drop lock on the eighth
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 6) chk("locked_after_7_errs", 64'(locked), 64'd1);
      if (k == 7) begin
        chk("unlock_after_8_errs", 64'(locked), 64'd0);
        chk("err_cnt_8", 64'(err_cnt), 64'd8);
      end
    end
    found = 0;
    for (int j = 0; j < 64; j++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (locked) begin
        found = 1;
        break;
      end
    end
    chk("relock_within_64", 64'(found), 64'd1);
    chk("err_cnt_kept_after_relock", 64'(err_cnt), 64'd8);

    // Table: error counting, pulse width, clear interaction
    for (int i = 0; i < 9; i++) begin
      step(tv[i].valid, tv[i].inv, tv[i].clr, 1'b0);
      chk($sformatf("vec%0d_locked", i), 64'(locked), 64'(tv[i].exp_locked));
      chk($sformatf("vec%0d_pulse", i), 64'(err_pulse), 64'(tv[i].exp_pulse));
      chk($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(tv[i].exp_err));
      if (i == 0) chk("clr_bit_cnt", 64'(bit_cnt), 64'd0);
    end

    // All-zero input never locks
    do_reset();
    saw_lock = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (locked) saw_lock = 1;
    end
    chk("zeros_no_lock", 64'(saw_lock), 64'd0);

    // Resume the stream: lock within 95 bits, then reset while locked
    found = 0;
    for (int i = 0; i <= 94; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (locked) begin
        found = 1;
        break;
      end
    end
    chk("lock_after_zeros", 64'(found), 64'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("err_before_reset", 64'(err_cnt), 64'd1);
    do_reset();
    found = 0;
    for (int i = 0; i <= 94; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (locked) begin
        found = 1;
        break;
      end
    end
    chk("relock_after_reset", 64'(found), 64'd1);

    // Randomized traffic with gaps, sparse errors, error bursts and clears
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 99) < 85);
      if (burst > 0) begin
        ri = 1'b1;
        if (rv) burst--;
      end else begin
        ri = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 399) == 0) burst = int'($urandom_range(8, 10));
      end
      rc = ($urandom_range(0, 49) == 0);
      step(rv, ri, rc, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
